// File: rtl/pipeline_ctrl_if.sv
// Memory request/response handshake between the pipeline sequencer (master)
// and the instruction/data memory ports (slave).
interface pipeline_ctrl_if;
   logic inst_read;
   logic inst_resp;
   logic data_read;
   logic data_write;
   logic data_resp;

   modport master (
      output inst_read, data_read, data_write,
      input  inst_resp, data_resp
   );

   modport slave (
      input  inst_read, data_read, data_write,
      output inst_resp, data_resp
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage RV32I pipeline sequencer: stage valid bits, register load enables,
// memory strobes, stall/load-use/redirect handling and saturating perf counters.
module pipeline_ctrl #(
   parameter int REDIRECT_STAGE = 3,
   parameter int REG_IDX_WIDTH  = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   pipeline_ctrl_if.master          mem_bus,
   input  logic                     mem_rd,
   input  logic                     mem_wr,
   input  logic                     redirect,
   input  logic [REG_IDX_WIDTH-1:0] id_rs1,
   input  logic [REG_IDX_WIDTH-1:0] id_rs2,
   input  logic                     id_uses_rs1,
   input  logic                     id_uses_rs2,
   input  logic                     ex_is_load,
   input  logic [REG_IDX_WIDTH-1:0] ex_rd,
   output logic                     load_pc,
   output logic                     load_if_id,
   output logic                     load_id_ex,
   output logic                     load_ex_mem,
   output logic                     load_mem_wb,
   output logic                     valid_id,
   output logic                     valid_ex,
   output logic                     valid_mem,
   output logic                     valid_wb,
   output logic                     retire,
   output logic [CNT_WIDTH-1:0]     stall_cnt,
   output logic [CNT_WIDTH-1:0]     bubble_cnt,
   output logic [CNT_WIDTH-1:0]     retire_cnt
);

   if (REDIRECT_STAGE != 2 && REDIRECT_STAGE != 3) begin : g_bad_redirect_stage
      $fatal(1, "pipeline_ctrl: REDIRECT_STAGE must be 2 (EX) or 3 (MEM)");
   end

   typedef enum logic [1:0] {
      ACT_NORMAL,
      ACT_HAZARD,
      ACT_REDIRECT,
      ACT_FREEZE
   } action_t;

   // Stages squashed by a redirect: ID up to and including the redirecting stage.
   localparam logic [4:1] SQUASH_MASK = (REDIRECT_STAGE == 2) ? 4'b0011 : 4'b0111;

   logic [4:1] valid_q;   // [1]=ID [2]=EX [3]=MEM [4]=WB
   logic [4:1] valid_d;
   logic       if_done;
   logic       dm_done;
   logic       dm_need;
   logic       adv;
   logic       hz;
   logic       rd;
   logic [4:0] loads;     // {pc, if_id, id_ex, ex_mem, mem_wb}
   action_t    action;

   assign valid_id  = valid_q[1];
   assign valid_ex  = valid_q[2];
   assign valid_mem = valid_q[3];
   assign valid_wb  = valid_q[4];

   assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = loads;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      dm_need = valid_q[3] & (mem_rd | mem_wr);
      adv     = (mem_bus.inst_resp | if_done)
              & (~dm_need | mem_bus.data_resp | dm_done);
      hz      = valid_q[1] & valid_q[2] & ex_is_load & (ex_rd != '0)
              & ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      rd      = redirect & valid_q[REDIRECT_STAGE];

      if (!adv)     action = ACT_FREEZE;
      else if (rd)  action = ACT_REDIRECT;
      else if (hz)  action = ACT_HAZARD;
      else          action = ACT_NORMAL;

      loads   = 5'b00000;
      valid_d = valid_q;
      unique case (action)
         ACT_FREEZE: ;
         ACT_REDIRECT: begin
            loads   = 5'b11111;
            valid_d = {valid_q[3:1], 1'b0} & ~SQUASH_MASK;
         end
         ACT_HAZARD: begin
            // ID holds its instruction; a bubble enters EX.
            loads   = 5'b00111;
            valid_d = {valid_q[3], valid_q[2], 1'b0, valid_q[1]};
         end
         default: begin
            loads   = 5'b11111;
            valid_d = {valid_q[3:1], 1'b1};
         end
      endcase

      retire             = valid_q[4] & adv;
      mem_bus.inst_read  = ~if_done;
      mem_bus.data_read  = valid_q[3] & mem_rd & ~dm_done;
      mem_bus.data_write = valid_q[3] & mem_wr & ~dm_done;

      if (rst) begin
         loads              = 5'b00000;
         retire             = 1'b0;
         mem_bus.inst_read  = 1'b0;
         mem_bus.data_read  = 1'b0;
         mem_bus.data_write = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= '0;
         if_done    <= 1'b0;
         dm_done    <= 1'b0;
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         retire_cnt <= '0;
      end else begin
         valid_q <= valid_d;
         if_done <= adv ? 1'b0 : (if_done | mem_bus.inst_resp);
         dm_done <= adv ? 1'b0 : (dm_done | mem_bus.data_resp);
         if (action == ACT_FREEZE && !(&stall_cnt))
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
         if ((action == ACT_REDIRECT || action == ACT_HAZARD) && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
         if (retire && !(&retire_cnt))
            retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: random stimulus drives a MEM-redirect instance
// and an EX-redirect instance with narrow counters, each against a stage-list model.
module tb_pipeline_ctrl;
   localparam int RW = 5;
   localparam int N_CYCLES = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          mem_rd, mem_wr, redirect;
   logic          id_uses_rs1, id_uses_rs2, ex_is_load;
   logic [RW-1:0] id_rs1, id_rs2, ex_rd;

   pipeline_ctrl_if bus3();
   pipeline_ctrl_if bus2();

   wire [4:0]  ld3, ld2;
   wire [4:1]  v3, v2;
   wire        ret3, ret2;
   wire [31:0] st3, bb3, rt3;
   wire [3:0]  st2, bb2, rt2;

   pipeline_ctrl #(.REDIRECT_STAGE(3), .REG_IDX_WIDTH(RW), .CNT_WIDTH(32)) dut3 (
      .clk(clk), .rst(rst), .mem_bus(bus3),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .redirect(redirect),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .load_pc(ld3[4]), .load_if_id(ld3[3]), .load_id_ex(ld3[2]), .load_ex_mem(ld3[1]),
      .load_mem_wb(ld3[0]),
      .valid_id(v3[1]), .valid_ex(v3[2]), .valid_mem(v3[3]), .valid_wb(v3[4]),
      .retire(ret3), .stall_cnt(st3), .bubble_cnt(bb3), .retire_cnt(rt3)
   );

   pipeline_ctrl #(.REDIRECT_STAGE(2), .REG_IDX_WIDTH(RW), .CNT_WIDTH(4)) dut2 (
      .clk(clk), .rst(rst), .mem_bus(bus2),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .redirect(redirect),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .load_pc(ld2[4]), .load_if_id(ld2[3]), .load_id_ex(ld2[2]), .load_ex_mem(ld2[1]),
      .load_mem_wb(ld2[0]),
      .valid_id(v2[1]), .valid_ex(v2[2]), .valid_mem(v2[3]), .valid_wb(v2[4]),
      .retire(ret2), .stall_cnt(st2), .bubble_cnt(bb2), .retire_cnt(rt2)
   );

   typedef struct packed {
      logic          rst, inst_resp, data_resp, mem_rd, mem_wr, redirect;
      logic          uses1, uses2, ex_is_load;
      logic [RW-1:0] rs1, rs2, ex_rd;
   } stim_t;

   // Occupancy of ID..WB plus outstanding-response flags and raw event counts.
   typedef struct packed {
      logic [4:1]  v;
      logic        if_done, dm_done;
      int unsigned stall, bubble, retired;
   } mstate_t;

   typedef struct packed {
      logic [4:0]  loads;    // {pc, if_id, id_ex, ex_mem, mem_wb}
      logic [2:0]  strobes;  // {inst_read, data_read, data_write}
      logic [4:1]  valids;
      logic        retire;
      logic [31:0] stall, bubble, retired;
   } obs_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   obs_t q3[$];
   obs_t q2[$];
   mstate_t m3, m2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] clamp(input int unsigned n, input int cw);
      longint unsigned cap;
      cap = (longint'(1) << cw) - 1;
      return (longint'(n) > cap) ? 32'(cap) : 32'(n);
   endfunction

   // One cycle of the pipeline rules: what the controller shows now, and the next state.
   task automatic model_step(input int stage, input int cw, input stim_t s,
                             inout mstate_t m, output obs_t o);
      bit need, adv, hz, take;
      o = '0;
      o.valids  = m.v;
      o.stall   = clamp(m.stall, cw);
      o.bubble  = clamp(m.bubble, cw);
      o.retired = clamp(m.retired, cw);
      if (s.rst) begin
         m = '0;
         return;
      end
      need = m.v[3] && (s.mem_rd || s.mem_wr);
      adv  = (s.inst_resp || m.if_done) && (!need || s.data_resp || m.dm_done);
      o.strobes = {!m.if_done, m.v[3] && s.mem_rd && !m.dm_done, m.v[3] && s.mem_wr && !m.dm_done};
      hz = m.v[1] && m.v[2] && s.ex_is_load && (s.ex_rd != 0)
         && ((s.uses1 && s.rs1 == s.ex_rd) || (s.uses2 && s.rs2 == s.ex_rd));
      take = s.redirect && m.v[stage];
      o.retire = m.v[4] && adv;
      if (o.retire) m.retired++;
      if (!adv) begin
         m.stall++;
         m.if_done = m.if_done || s.inst_resp;
         m.dm_done = m.dm_done || s.data_resp;
      end else begin
         m.if_done = 1'b0;
         m.dm_done = 1'b0;
         if (take) begin
            o.loads = 5'b11111;
            m.v = {m.v[3:1], 1'b0};
            for (int k = 1; k <= stage; k++) m.v[k] = 1'b0;
            m.bubble++;
         end else if (hz) begin
            o.loads = 5'b00111;
            m.v = {m.v[3], m.v[2], 1'b0, m.v[1]};
            m.bubble++;
         end else begin
            o.loads = 5'b11111;
            m.v = {m.v[3:1], 1'b1};
         end
      end
   endtask

   // Responses only answer an outstanding request, except during reset where they must be ignored.
   task automatic gen_resp(input mstate_t m, input stim_t base, output stim_t s);
      s = base;
      s.inst_resp = (s.rst || !m.if_done) && ($urandom_range(0, 99) < 55);
      s.data_resp = (s.rst || (m.v[3] && (s.mem_rd || s.mem_wr) && !m.dm_done))
                  && ($urandom_range(0, 99) < 45);
   endtask

   task automatic compare(input string tag, input obs_t e, input obs_t a);
      check($sformatf("%s loads c%0d", tag, cyc), 32'(a.loads), 32'(e.loads));
      check($sformatf("%s strobes c%0d", tag, cyc), 32'(a.strobes), 32'(e.strobes));
      check($sformatf("%s valids c%0d", tag, cyc), 32'(a.valids), 32'(e.valids));
      check($sformatf("%s retire c%0d", tag, cyc), 32'(a.retire), 32'(e.retire));
      check($sformatf("%s stall_cnt c%0d", tag, cyc), a.stall, e.stall);
      check($sformatf("%s bubble_cnt c%0d", tag, cyc), a.bubble, e.bubble);
      check($sformatf("%s retire_cnt c%0d", tag, cyc), a.retired, e.retired);
   endtask

   initial begin : monitor
      obs_t a;
      forever begin
         @(negedge clk);
         if (q3.size() > 0) begin
            a = {ld3, bus3.inst_read, bus3.data_read, bus3.data_write, v3, ret3, st3, bb3, rt3};
            compare("mem_redirect", q3.pop_front(), a);
         end
         if (q2.size() > 0) begin
            a = {ld2, bus2.inst_read, bus2.data_read, bus2.data_write, v2, ret2,
                 28'(0), st2, 28'(0), bb2, 28'(0), rt2};
            compare("ex_redirect", q2.pop_front(), a);
         end
      end
   end

   initial begin : driver
      stim_t base, s3, s2;
      obs_t  e3, e2;
      int    sel;
      rst = 1'b1;
      {mem_rd, mem_wr, redirect, id_uses_rs1, id_uses_rs2, ex_is_load} = '0;
      {id_rs1, id_rs2, ex_rd} = '0;
      {bus3.inst_resp, bus3.data_resp, bus2.inst_resp, bus2.data_resp} = '0;
      m3 = '0;
      m2 = '0;
      @(posedge clk);
      for (int c = 0; c < N_CYCLES; c++) begin
         #1;
         cyc = c;
         sel = int'($urandom_range(0, 3));
         base.rst        = (c < 2) || ($urandom_range(0, 999) < 15);
         base.mem_rd     = (sel == 1);
         base.mem_wr     = (sel == 2);
         base.redirect   = ($urandom_range(0, 99) < 12);
         base.uses1      = 1'($urandom_range(0, 1));
         base.uses2      = 1'($urandom_range(0, 1));
         base.ex_is_load = 1'($urandom_range(0, 1));
         base.rs1        = RW'($urandom_range(0, 3));
         base.rs2        = RW'($urandom_range(0, 3));
         base.ex_rd      = RW'($urandom_range(0, 3));
         base.inst_resp  = 1'b0;
         base.data_resp  = 1'b0;
         gen_resp(m3, base, s3);
         gen_resp(m2, base, s2);

         rst         = base.rst;
         mem_rd      = base.mem_rd;
         mem_wr      = base.mem_wr;
         redirect    = base.redirect;
         id_uses_rs1 = base.uses1;
         id_uses_rs2 = base.uses2;
         ex_is_load  = base.ex_is_load;
         id_rs1      = base.rs1;
         id_rs2      = base.rs2;
         ex_rd       = base.ex_rd;
         bus3.inst_resp = s3.inst_resp;
         bus3.data_resp = s3.data_resp;
         bus2.inst_resp = s2.inst_resp;
         bus2.data_resp = s2.data_resp;

         model_step(3, 32, s3, m3, e3);
         model_step(2, 4, s2, m2, e2);
         q3.push_back(e3);
         q2.push_back(e2);
         @(posedge clk);
      end
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      check("mem_redirect queue drained", 32'(q3.size()), 32'd0);
      check("ex_redirect queue drained", 32'(q2.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
